// File: rtl/alu16_pkg.sv
// alu16_pkg: shared op/state encodings and F bit positions for the 16-bit ALU sequencer
package alu16_pkg;
  typedef enum logic [2:0] {
    OP_LDHL_SPE = 3'd0,
    OP_ADD_SPE  = 3'd1,
    OP_ADD_HLRR = 3'd2,
    OP_INC_RR   = 3'd3,
    OP_DEC_RR   = 3'd4
  } alu16_op_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} alu16_state_t;
  localparam int FLAG_Z = 7;
  localparam int FLAG_N = 6;
  localparam int FLAG_H = 5;
  localparam int FLAG_C = 4;
  function automatic logic is_spe(alu16_op_t o);
    return o == OP_LDHL_SPE || o == OP_ADD_SPE;
  endfunction
endpackage

// File: rtl/alu16_seq_add8.sv
// add8: 8-bit adder exposing nibble carry (c4) and byte carry (c8)
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       c4,
  output logic       c8
);
  logic [4:0] lo, hi;
  assign lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign hi  = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, lo[4]};
  assign sum = {hi[3:0], lo[3:0]};
  assign c4  = lo[4];
  assign c8  = hi[4];
endmodule

// File: rtl/alu16_seq.sv
// alu16_seq: 16-bit add sequenced as low-byte then high-byte pass through one shared add8
import alu16_pkg::*;
module alu16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        start,
  input  alu16_op_t   op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  input  logic [7:0]  f_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] res,
  output logic [7:0]  f_out,
  output logic        f_we
);
  alu16_state_t state_q;
  alu16_op_t    op_q;
  logic [15:0]  a_q, b_q, b_d, res_q;
  logic [7:0]   f_in_q, f_out_q, f_calc, add_a, add_b, sum;
  logic         c8_q, busy_q, done_q, f_we_q, c4, c8, incdec;
  assign b_d = is_spe(op) ? {{8{opb[7]}}, opb[7:0]} :
               op == OP_ADD_HLRR ? opb :
               op == OP_INC_RR ? 16'h0001 : 16'hFFFF;
  assign add_a  = state_q == ST_HI ? a_q[15:8] : a_q[7:0];
  assign add_b  = state_q == ST_HI ? b_q[15:8] : b_q[7:0];
  assign incdec = op_q == OP_INC_RR || op_q == OP_DEC_RR;
  add8 u_add8 (
    .a(add_a), .b(add_b), .cin(state_q == ST_HI && c8_q),
    .sum(sum), .c4(c4), .c8(c8)
  );
  // In the high pass the nibble carry is the carry out of bit 11
  always_comb begin
    f_calc         = '0;
    f_calc[FLAG_Z] = op_q == OP_ADD_HLRR && f_in_q[FLAG_Z];
    f_calc[FLAG_H] = c4;
    f_calc[FLAG_C] = c8;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      f_we_q  <= 1'b0;
      res_q   <= '0;
      f_out_q <= '0;
      c8_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          op_q    <= op;
          a_q     <= opa;
          b_q     <= b_d;
          f_in_q  <= f_in;
          busy_q  <= 1'b1;
          state_q <= ST_LO;
        end
        ST_LO: if (ce) begin
          res_q[7:0] <= sum;
          c8_q       <= c8;
          state_q    <= ST_HI;
        end
        ST_HI: if (ce) begin
          res_q[15:8] <= sum;
          f_out_q     <= incdec ? f_in_q : f_calc;
          f_we_q      <= !incdec;
          done_q      <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          f_we_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end
  assign busy  = busy_q;
  assign done  = done_q;
  assign res   = res_q;
  assign f_out = f_out_q;
  assign f_we  = f_we_q;
endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: random + directed scoreboard bench for alu16_seq against an arithmetic reference model
import alu16_pkg::*;
module tb_alu16_seq;
  logic clk = 0, reset = 1, ce = 0, start = 0;
  alu16_op_t op = OP_INC_RR;
  logic [15:0] opa = 0, opb = 0, res;
  logic [7:0] f_in = 0, f_out;
  logic busy, done, f_we;
  int checks = 0, errors = 0;
  typedef struct {logic [15:0] res; logic [7:0] f; logic we;} exp_t;
  exp_t sb[$];

  alu16_seq dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .op(op), .opa(opa), .opb(opb),
    .f_in(f_in), .busy(busy), .done(done), .res(res), .f_out(f_out), .f_we(f_we)
  );

  always #5 clk = ~clk;

  task automatic check(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  function automatic exp_t model(alu16_op_t o, logic [15:0] a, logic [15:0] b, logic [7:0] f);
    exp_t r;
    int unsigned bv, s;
    logic h, c;
    if (o == OP_LDHL_SPE || o == OP_ADD_SPE) bv = b[7] ? ('hFF00 | b[7:0]) : b[7:0];
    else if (o == OP_ADD_HLRR) bv = b;
    else if (o == OP_INC_RR) bv = 1;
    else bv = 'hFFFF;
    s = a + bv;
    h = ((a & 'hFFF) + (bv & 'hFFF)) >= 'h1000;
    c = s > 'hFFFF;
    r.res = s[15:0];
    if (o == OP_INC_RR || o == OP_DEC_RR) begin
      r.f = f;
      r.we = 0;
    end else begin
      r.f = {(o == OP_ADD_HLRR) ? f[7] : 1'b0, 1'b0, h, c, 4'b0000};
      r.we = 1;
    end
    return r;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) if (done) begin
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL spurious_done act=%h exp=none", res);
    end else begin
      exp_t e;
      e = sb.pop_front();
      check("res", res, e.res);
      check("f_out", {8'h0, f_out}, {8'h0, e.f});
      check("f_we", {15'h0, f_we}, {15'h0, e.we});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input alu16_op_t o, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] f, input int g0, input int g1, input bit noise);
    tick();
    start = 1; op = o; opa = a; opb = b; f_in = f;
    tick();
    start = 0;
    sb.push_back(model(o, a, b, f));
    opa = 16'($urandom); opb = 16'($urandom); f_in = 8'($urandom);
    check("busy_accept", {15'h0, busy}, 16'h1);
    if (noise) begin
      start = 1;
      op = OP_INC_RR;
    end
    repeat (g0) tick();
    ce = 1;
    tick();
    ce = 0; start = 0;
    check("no_early_done", {15'h0, done}, 16'h0);
    repeat (g1) tick();
    ce = 1;
    tick();
    ce = 0;
    check("done_latency", {15'h0, done}, 16'h1);
    if (noise) start = 1;
    tick();
    start = 0;
    check("busy_drop", {15'h0, busy}, 16'h0);
    if (noise) begin
      ce = 1;
      tick();
      ce = 0;
      check("idle_ce_ignored", {15'h0, busy}, 16'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 0;
    check("rst_busy", {15'h0, busy}, 16'h0);
    check("rst_done", {15'h0, done}, 16'h0);
    check("rst_fwe", {15'h0, f_we}, 16'h0);
    check("rst_res", res, 16'h0000);
    check("rst_fout", {8'h0, f_out}, 16'h0000);
    run_op(OP_LDHL_SPE, 16'hFFF8, 16'h0008, 8'h00, 0, 0, 0);
    run_op(OP_LDHL_SPE, 16'h0FFF, 16'h0001, 8'h00, 1, 0, 0);
    run_op(OP_ADD_SPE,  16'h0000, 16'hAAFF, 8'hF0, 0, 2, 0);
    run_op(OP_ADD_HLRR, 16'h8000, 16'h8000, 8'h80, 0, 0, 0);
    run_op(OP_ADD_HLRR, 16'h0FFF, 16'h0001, 8'h00, 2, 1, 0);
    run_op(OP_INC_RR,   16'hFFFF, 16'h1234, 8'hB0, 0, 0, 0);
    run_op(OP_DEC_RR,   16'h0000, 16'h1234, 8'h50, 0, 0, 0);
    run_op(OP_ADD_HLRR, 16'h1234, 16'h4321, 8'h80, 3, 3, 1);
    // Reset during the high pass: op is dropped, no done may follow
    tick();
    start = 1; op = OP_INC_RR; opa = 16'h1234;
    tick();
    start = 0; ce = 1;
    tick();
    ce = 0;
    reset = 1;
    tick();
    reset = 0;
    check("midrst_busy", {15'h0, busy}, 16'h0);
    check("midrst_res", res, 16'h0000);
    check("midrst_done", {15'h0, done}, 16'h0);
    ce = 1;
    repeat (3) tick();
    ce = 0;
    run_op(OP_ADD_SPE, 16'hD000, 16'h0080, 8'h00, 0, 1, 0);
    for (int i = 0; i < 40; i++)
      run_op(alu16_op_t'($urandom_range(0, 4)), 16'($urandom), 16'($urandom), 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    repeat (4) tick();
    check("sb_empty", 16'(sb.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
